sa_cache_4way: RTL and testbench

Four-way set-associative, write-back, write-allocate cache for one 32-bit word per line, sitting between a core-side access port and a backing-memory refill/eviction port. It decodes a pre-split address (18-bit tag, 8-bit index, 6-bit offset) into 256 sets. Hits complete in one cycle. Misses stall with `cache_miss` high, optionally evict a dirty victim, then wait for a memory refill.

---
 rtl/sa_cache_pkg.sv | 19 +
 rtl/sa_cache_repl.sv | 83 ++++++++
 rtl/sa_cache_4way.sv | 166 ++++++++++++++++
 tb/tb_sa_cache_4way.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sa_cache_pkg.sv
// Shared definitions for the four-way set-associative cache.
// Holds the default geometry, the controller state encoding and the way-index
// type used by the top level and the replacement sub-module.
package sa_cache_pkg;
   localparam int TAG_W    = 18;
   localparam int INDEX_W  = 8;
   localparam int OFFSET_W = 6;
   localparam int DATA_W   = 32;
   localparam int NUM_WAYS = 4;
   localparam int NUM_SETS = 256;

   typedef enum logic [1:0] {
      IDLE,
      EVICT,
      WAIT_MEM
   } state_t;

   typedef logic [1:0] way_t;
endpackage

// File: rtl/sa_cache_repl.sv
// Per-set replacement state, victim selection and update for sa_cache_4way.
// Optional feature macro: SA_CACHE_PLRU_EN
//   defined     : 3-bit tree pseudo-LRU per set, touched on every hit and fill
//   not defined : 2-bit round-robin counter per set, advanced on every fill only
// Ports:
//   clk, rst       clock, synchronous active-low reset (clears all state)
//   lookup_index   set currently being looked up
//   valid_set      valid bits of the looked-up set (invalid ways win first)
//   victim         way to replace on a miss in the looked-up set
//   upd_en         replacement update strobe
//   upd_fill       the update is a fill (as opposed to a hit)
//   upd_index      set to update
//   upd_way        way that was accessed or filled
module sa_cache_repl
   import sa_cache_pkg::*;
#(
   parameter int IDX_W = sa_cache_pkg::INDEX_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    lookup_index,
   input  logic [NUM_WAYS-1:0] valid_set,
   output way_t                victim,
   input  logic                upd_en,
   input  logic                upd_fill,
   input  logic [IDX_W-1:0]    upd_index,
   input  way_t                upd_way
);

   localparam int SETS = 2 ** IDX_W;

   way_t policy_way;

`ifdef SA_CACHE_PLRU_EN
   // Bit 0 is the root (0 = left half, ways 0/1); bit 1 picks within the left
   // half, bit 2 within the right half. Each bit points at the next victim.
   logic [2:0] plru_q [SETS];

   wire unused_fill = upd_fill;

   always_comb begin
      if (!plru_q[lookup_index][0])
         policy_way = {1'b0, plru_q[lookup_index][1]};
      else
         policy_way = {1'b1, plru_q[lookup_index][2]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (upd_en) begin
         // Point every bit on the accessed path away from the accessed way.
         plru_q[upd_index][0] <= ~upd_way[1];
         if (!upd_way[1])
            plru_q[upd_index][1] <= ~upd_way[0];
         else
            plru_q[upd_index][2] <= ~upd_way[0];
      end
   end
`else
   way_t rr_q [SETS];

   wire unused_way = ^upd_way;

   assign policy_way = rr_q[lookup_index];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (upd_en && upd_fill) begin
         rr_q[upd_index] <= way_t'(rr_q[upd_index] + 2'd1);
      end
   end
`endif

   // Lowest-numbered invalid way takes precedence over the policy choice.
   always_comb begin
      victim = policy_way;
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!valid_set[w]) victim = way_t'(w);
   end

endmodule

// File: rtl/sa_cache_4way.sv
// Four-way set-associative, write-back, write-allocate cache with one word per
// line. Hits complete in one cycle; misses raise cache_miss, optionally evict a
// dirty victim for one cycle, then wait for a memory refill.
// Optional feature macro: SA_CACHE_PLRU_EN (tree pseudo-LRU instead of
// round-robin replacement; see sa_cache_repl).
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   i_tag/i_index/i_offset access address (held stable while cache_miss=1)
//   dataW, memRW          write data, 1 = write / 0 = read
//   i_memory_line         refill data, valid with i_memory_response
//   o_data                read data, or the written data
//   line_data             last refilled line
//   cache_miss            high while a miss is outstanding
//   o_evict               one-cycle eviction strobe
//   o_evict_data/addr     victim line and {tag, index, 0} address
module sa_cache_4way
   import sa_cache_pkg::*;
#(
   parameter int TAG_W    = sa_cache_pkg::TAG_W,
   parameter int INDEX_W  = sa_cache_pkg::INDEX_W,
   parameter int OFFSET_W = sa_cache_pkg::OFFSET_W,
   parameter int DATA_W   = sa_cache_pkg::DATA_W
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [TAG_W-1:0]                   i_tag,
   input  logic [INDEX_W-1:0]                 i_index,
   input  logic [OFFSET_W-1:0]                i_offset,
   input  logic [DATA_W-1:0]                  dataW,
   input  logic                               memRW,
   input  logic [DATA_W-1:0]                  i_memory_line,
   input  logic                               i_memory_response,
   output logic [DATA_W-1:0]                  o_data,
   output logic [DATA_W-1:0]                  line_data,
   output logic                               cache_miss,
   output logic [DATA_W-1:0]                  o_evict_data,
   output logic [TAG_W+INDEX_W+OFFSET_W-1:0]  o_evict_addr,
   output logic                               o_evict
);

   localparam int SETS = 2 ** INDEX_W;

   logic [NUM_WAYS-1:0] valid_q [SETS];
   logic [NUM_WAYS-1:0] dirty_q [SETS];
   logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
   logic [DATA_W-1:0]   data_q  [SETS][NUM_WAYS];

   state_t state_q;
   way_t   victim_q;
   way_t   victim;
   way_t   hit_way;
   logic [NUM_WAYS-1:0] hit_vec;
   logic   hit;
   logic   hit_fire;
   logic   fill_fire;
   logic   victim_dirty;
   logic [DATA_W-1:0] fill_data;

   // The line offset only matters to the backing memory; evictions are line aligned.
   wire unused_offset = ^i_offset;

   always_comb begin
      for (int w = 0; w < NUM_WAYS; w++)
         hit_vec[w] = valid_q[i_index][w] && (tag_q[i_index][w] == i_tag);
   end

   assign hit = |hit_vec;

   // NOTE: assign a default before the loop so no path leaves hit_way unassigned (no latch).
   always_comb begin
      hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (hit_vec[w]) hit_way = way_t'(w);
   end

   assign hit_fire     = (state_q == IDLE) && hit;
   assign fill_fire    = (state_q == WAIT_MEM) && i_memory_response;
   assign victim_dirty = valid_q[i_index][victim] && dirty_q[i_index][victim];
   assign fill_data    = memRW ? dataW : i_memory_line;

   sa_cache_repl #(
      .IDX_W (INDEX_W)
   ) u_repl (
      .clk          (clk),
      .rst          (rst),
      .lookup_index (i_index),
      .valid_set    (valid_q[i_index]),
      .victim       (victim),
      .upd_en       (rst && (hit_fire || fill_fire)),
      .upd_fill     (fill_fire),
      .upd_index    (i_index),
      .upd_way      (fill_fire ? victim_q : hit_way)
   );

   // NOTE: tag and data storage carry no reset; valid bits alone decide whether
   // their contents mean anything, so clearing them would only cost logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (hit_fire && memRW)
            data_q[i_index][hit_way] <= dataW;
         else if (fill_fire) begin
            data_q[i_index][victim_q] <= fill_data;
            tag_q[i_index][victim_q]  <= i_tag;
         end
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         victim_q     <= '0;
         o_data       <= '0;
         line_data    <= '0;
         cache_miss   <= 1'b0;
         o_evict      <= 1'b0;
         o_evict_data <= '0;
         o_evict_addr <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  if (memRW) begin
                     dirty_q[i_index][hit_way] <= 1'b1;
                     o_data                    <= dataW;
                  end else begin
                     o_data <= data_q[i_index][hit_way];
                  end
               end else begin
                  cache_miss <= 1'b1;
                  victim_q   <= victim;
                  if (victim_dirty) begin
                     state_q      <= EVICT;
                     o_evict      <= 1'b1;
                     o_evict_data <= data_q[i_index][victim];
                     o_evict_addr <= {tag_q[i_index][victim], i_index, {OFFSET_W{1'b0}}};
                  end else begin
                     state_q <= WAIT_MEM;
                  end
               end
            end
            EVICT: begin
               o_evict <= 1'b0;
               state_q <= WAIT_MEM;
            end
            WAIT_MEM: begin
               if (i_memory_response) begin
                  valid_q[i_index][victim_q] <= 1'b1;
                  dirty_q[i_index][victim_q] <= memRW;
                  line_data                  <= i_memory_line;
                  o_data                     <= fill_data;
                  cache_miss                 <= 1'b0;
                  state_q                    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sa_cache_4way.sv
// Directed self-checking bench for sa_cache_4way (default round-robin build).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the
// following rising edge.
module tb_sa_cache_4way;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] i_tag;
   logic [7:0]  i_index;
   logic [5:0]  i_offset;
   logic [31:0] dataW;
   logic        memRW;
   logic [31:0] i_memory_line;
   logic        i_memory_response;
   logic [31:0] o_data;
   logic [31:0] line_data;
   logic        cache_miss;
   logic [31:0] o_evict_data;
   logic [31:0] o_evict_addr;
   logic        o_evict;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sa_cache_4way dut (
      .clk               (clk),
      .rst               (rst),
      .i_tag             (i_tag),
      .i_index           (i_index),
      .i_offset          (i_offset),
      .dataW             (dataW),
      .memRW             (memRW),
      .i_memory_line     (i_memory_line),
      .i_memory_response (i_memory_response),
      .o_data            (o_data),
      .line_data         (line_data),
      .cache_miss        (cache_miss),
      .o_evict_data      (o_evict_data),
      .o_evict_addr      (o_evict_addr),
      .o_evict           (o_evict)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [17:0] tag, input logic [7:0] idx,
                          input logic rw, input logic [31:0] wd);
      i_tag   = tag;
      i_index = idx;
      memRW   = rw;
      dataW   = wd;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      i_offset = 6'h3;
      i_memory_response = 1'b0;
      i_memory_line = 32'h0;
      present(18'h0, 8'h0, 1'b0, 32'h0);
      step();
      rst = 1'b1;
      n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset o_data: got %h want 0", o_data); end
      n_checks++; if (line_data !== 32'h0) begin n_fail++; $display("FAIL reset line_data: got %h want 0", line_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL reset cache_miss: got %b want 0", cache_miss); end
      n_checks++; if (o_evict !== 1'b0) begin n_fail++; $display("FAIL reset o_evict: got %b want 0", o_evict); end
      n_checks++; if (o_evict_addr !== 32'h0) begin n_fail++; $display("FAIL reset o_evict_addr: got %h want 0", o_evict_addr); end
      n_checks++; if (o_evict_data !== 32'h0) begin n_fail++; $display("FAIL reset o_evict_data: got %h want 0", o_evict_data); end
   endtask

   task automatic test_cold_read();
      present(18'h00001, 8'h05, 1'b0, 32'h0);
      step();
      n_checks++; if (cache_miss !== 1'b1) begin n_fail++; $display("FAIL cold cache_miss: got %b want 1", cache_miss); end
      n_checks++; if (o_evict !== 1'b0) begin n_fail++; $display("FAIL cold o_evict: got %b want 0", o_evict); end
      i_memory_response = 1'b1;
      i_memory_line = 32'hDEADBEEF;
      step();
      i_memory_response = 1'b0;
      n_checks++; if (line_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cold line_data: got %h want deadbeef", line_data); end
      n_checks++; if (o_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cold o_data: got %h want deadbeef", o_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL cold miss cleared: got %b want 0", cache_miss); end
   endtask

   task automatic test_read_hit();
      present(18'h00001, 8'h05, 1'b0, 32'h0);
      step();
      n_checks++; if (o_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_hit o_data: got %h want deadbeef", o_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL read_hit cache_miss: got %b want 0", cache_miss); end
   endtask

   task automatic test_write_hit();
      present(18'h00001, 8'h05, 1'b1, 32'h12345678);
      step();
      n_checks++; if (o_data !== 32'h12345678) begin n_fail++; $display("FAIL write_hit o_data: got %h want 12345678", o_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL write_hit cache_miss: got %b want 0", cache_miss); end
      present(18'h00001, 8'h05, 1'b0, 32'h0);
      step();
      n_checks++; if (o_data !== 32'h12345678) begin n_fail++; $display("FAIL write_hit readback: got %h want 12345678", o_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL write_hit readback miss: got %b want 0", cache_miss); end
   endtask

   task automatic test_dirty_evict();
      // Tags 2..4 land in the three remaining invalid ways of set 5.
      for (int t = 2; t <= 4; t++) begin
         present(18'(t), 8'h05, 1'b0, 32'h0);
         step();
         n_checks++; if (cache_miss !== 1'b1) begin n_fail++; $display("FAIL fill%0d cache_miss: got %b want 1", t, cache_miss); end
         i_memory_response = 1'b1;
         i_memory_line = 32'hA0000000 + 32'(t);
         step();
         i_memory_response = 1'b0;
         n_checks++; if (o_data !== 32'hA0000000 + 32'(t)) begin n_fail++; $display("FAIL fill%0d o_data: got %h want %h", t, o_data, 32'hA0000000 + 32'(t)); end
      end
      for (int t = 2; t <= 4; t++) begin
         present(18'(t), 8'h05, 1'b0, 32'h0);
         step();
         n_checks++; if (o_data !== 32'hA0000000 + 32'(t)) begin n_fail++; $display("FAIL rehit%0d o_data: got %h want %h", t, o_data, 32'hA0000000 + 32'(t)); end
         n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL rehit%0d cache_miss: got %b want 0", t, cache_miss); end
      end
      // Four fills wrapped the round-robin pointer back to way 0 (tag 1, dirty).
      present(18'h00005, 8'h05, 1'b0, 32'h0);
      step();
      n_checks++; if (cache_miss !== 1'b1) begin n_fail++; $display("FAIL evict cache_miss: got %b want 1", cache_miss); end
      n_checks++; if (o_evict !== 1'b1) begin n_fail++; $display("FAIL evict strobe: got %b want 1", o_evict); end
      n_checks++; if (o_evict_addr !== 32'h00004140) begin n_fail++; $display("FAIL evict addr: got %h want 00004140", o_evict_addr); end
      n_checks++; if (o_evict_data !== 32'h12345678) begin n_fail++; $display("FAIL evict data: got %h want 12345678", o_evict_data); end
      step();
      n_checks++; if (o_evict !== 1'b0) begin n_fail++; $display("FAIL evict strobe drop: got %b want 0", o_evict); end
      n_checks++; if (cache_miss !== 1'b1) begin n_fail++; $display("FAIL evict wait miss: got %b want 1", cache_miss); end
      n_checks++; if (o_evict_addr !== 32'h00004140) begin n_fail++; $display("FAIL evict addr hold: got %h want 00004140", o_evict_addr); end
      i_memory_response = 1'b1;
      i_memory_line = 32'h55555555;
      step();
      i_memory_response = 1'b0;
      n_checks++; if (o_data !== 32'h55555555) begin n_fail++; $display("FAIL evict refill o_data: got %h want 55555555", o_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL evict refill miss: got %b want 0", cache_miss); end
      step();
      n_checks++; if (o_data !== 32'h55555555) begin n_fail++; $display("FAIL tag5 rehit o_data: got %h want 55555555", o_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL tag5 rehit miss: got %b want 0", cache_miss); end
   endtask

   task automatic test_stray_response();
      present(18'h00005, 8'h05, 1'b0, 32'h0);
      i_memory_response = 1'b1;
      i_memory_line = 32'hFFFFFFFF;
      step();
      i_memory_response = 1'b0;
      n_checks++; if (line_data !== 32'h55555555) begin n_fail++; $display("FAIL stray line_data: got %h want 55555555", line_data); end
      n_checks++; if (o_data !== 32'h55555555) begin n_fail++; $display("FAIL stray o_data: got %h want 55555555", o_data); end
      present(18'h00002, 8'h05, 1'b0, 32'h0);
      step();
      n_checks++; if (o_data !== 32'hA0000002) begin n_fail++; $display("FAIL stray array: got %h want a0000002", o_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL stray miss: got %b want 0", cache_miss); end
   endtask

   task automatic test_reset_mid_miss();
      // Tag 1 was evicted; the clean victim now is way 1, so no eviction.
      present(18'h00001, 8'h05, 1'b0, 32'h0);
      step();
      n_checks++; if (cache_miss !== 1'b1) begin n_fail++; $display("FAIL midmiss miss: got %b want 1", cache_miss); end
      n_checks++; if (o_evict !== 1'b0) begin n_fail++; $display("FAIL midmiss evict: got %b want 0", o_evict); end
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL midmiss reset miss: got %b want 0", cache_miss); end
      n_checks++; if (line_data !== 32'h0) begin n_fail++; $display("FAIL midmiss reset line_data: got %h want 0", line_data); end
      step();
      n_checks++; if (cache_miss !== 1'b1) begin n_fail++; $display("FAIL post-reset miss: got %b want 1", cache_miss); end
      n_checks++; if (o_evict !== 1'b0) begin n_fail++; $display("FAIL post-reset evict: got %b want 0", o_evict); end
      i_memory_response = 1'b1;
      i_memory_line = 32'h0BADF00D;
      step();
      i_memory_response = 1'b0;
      n_checks++; if (o_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL post-reset refill: got %h want 0badf00d", o_data); end
   endtask

   task automatic test_write_miss();
      present(18'h00007, 8'h06, 1'b1, 32'hCAFE0000);
      step();
      n_checks++; if (cache_miss !== 1'b1) begin n_fail++; $display("FAIL wmiss miss: got %b want 1", cache_miss); end
      i_memory_response = 1'b1;
      i_memory_line = 32'h11111111;
      step();
      i_memory_response = 1'b0;
      n_checks++; if (o_data !== 32'hCAFE0000) begin n_fail++; $display("FAIL wmiss o_data: got %h want cafe0000", o_data); end
      n_checks++; if (line_data !== 32'h11111111) begin n_fail++; $display("FAIL wmiss line_data: got %h want 11111111", line_data); end
      present(18'h00007, 8'h06, 1'b0, 32'h0);
      step();
      n_checks++; if (o_data !== 32'hCAFE0000) begin n_fail++; $display("FAIL wmiss readback: got %h want cafe0000", o_data); end
      n_checks++; if (cache_miss !== 1'b0) begin n_fail++; $display("FAIL wmiss readback miss: got %b want 0", cache_miss); end
   endtask

   initial begin
      rst = 1'b0;
      #2;
      test_reset();
      test_cold_read();
      test_read_hit();
      test_write_hit();
      test_dirty_evict();
      test_stray_response();
      test_reset_mid_miss();
      test_write_miss();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
